// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with prescaler, wrap/saturate limit handling,
// a registered terminal-count pulse and a registered step pulse.
module mod_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic             up_down,
    input  logic             mode,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             tick,
    output logic             at_max,
    output logic             at_min
);

    localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

    if (MAX_VAL < 1 || MAX_VAL > (2**WIDTH) - 1) begin : g_bad_max
        $error("mod_updown_counter: MAX_VAL must lie in 1 .. 2**WIDTH-1");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("mod_updown_counter: PRESCALE must be >= 1");
    end

    logic [WIDTH-1:0] count_p0;
    logic [PS_W-1:0]  ps_p0;
    logic             tc_p0;
    logic             tick_p0;
    logic             step;
    logic             limit_hit;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_C) ? MAX_C : v;
    endfunction

    // At the limit a step either wraps to the opposite end or holds (saturate).
    function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] c,
                                                    input logic up,
                                                    input logic sat);
        if (up) begin
            if (c == MAX_C) return sat ? c : '0;
            return c + WIDTH'(1);
        end
        if (c == '0) return sat ? c : MAX_C;
        return c - WIDTH'(1);
    endfunction

    always_comb begin
        step      = enable && !load && (ps_p0 == PS_LAST);
        limit_hit = up_down ? (count_p0 == MAX_C) : (count_p0 == '0);
    end

    // Stage p0: count, prescaler and pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_p0 <= '0;
            ps_p0    <= '0;
            tc_p0    <= 1'b0;
            tick_p0  <= 1'b0;
        end else if (load) begin
            count_p0 <= clamp_load(d_in);
            ps_p0    <= '0;
            tc_p0    <= 1'b0;
            tick_p0  <= 1'b0;
        end else begin
            tick_p0 <= step;
            tc_p0   <= step && limit_hit;
            if (enable) begin
                ps_p0 <= (ps_p0 == PS_LAST) ? '0 : ps_p0 + PS_W'(1);
            end
            if (step) begin
                count_p0 <= step_count(count_p0, up_down, mode);
            end
        end
    end

    assign count  = count_p0;
    assign tc     = tc_p0;
    assign tick   = tick_p0;
    assign at_max = (count_p0 == MAX_C);
    assign at_min = (count_p0 == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: a 4-bit MAX_VAL=9 PRESCALE=3 instance
// and an 8-bit full-range PRESCALE=1 instance.
module tb_mod_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=4, MAX_VAL=9, PRESCALE=3
    logic       rst_n = 1'b0, enable = 1'b0, load = 1'b0, up_down = 1'b1, mode = 1'b0;
    logic [3:0] d_in = '0;
    logic [3:0] count_a;
    logic       tc_a, tick_a, at_max_a, at_min_a;

    // Instance B: WIDTH=8, MAX_VAL=255, PRESCALE=1
    logic       rst_n_b = 1'b0, en_b = 1'b0, ld_b = 1'b0, ud_b = 1'b1, md_b = 1'b0;
    logic [7:0] d_b = '0;
    logic [7:0] count_b;
    logic       tc_b, tick_b, at_max_b, at_min_b;

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .up_down(up_down),
        .mode(mode), .d_in(d_in), .count(count_a), .tc(tc_a), .tick(tick_a),
        .at_max(at_max_a), .at_min(at_min_a)
    );

    mod_updown_counter #(.WIDTH(8), .MAX_VAL(255), .PRESCALE(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .enable(en_b), .load(ld_b), .up_down(ud_b),
        .mode(md_b), .d_in(d_b), .count(count_b), .tc(tc_b), .tick(tick_b),
        .at_max(at_max_b), .at_min(at_min_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected {count, tc, tick, at_max, at_min} per driven cycle
    logic [7:0]  sb_q[$];
    logic [11:0] sb_b[$];

    // Behavioural model of instance A
    int m_count = 0;
    int m_ps    = 0;
    bit m_tc    = 0;
    bit m_tick  = 0;

    task automatic apply(input bit rn, input bit en, input bit ld, input bit ud,
                         input bit md, input int d);
        bit step;
        rst_n = rn; enable = en; load = ld; up_down = ud; mode = md; d_in = d[3:0];
        if (!rn) begin
            m_count = 0; m_ps = 0; m_tc = 0; m_tick = 0;
        end else if (ld) begin
            m_count = (d > 9) ? 9 : d; m_ps = 0; m_tc = 0; m_tick = 0;
        end else begin
            step   = en && (m_ps == 2);
            if (en) m_ps = (m_ps + 1) % 3;
            m_tick = step;
            m_tc   = 0;
            if (step) begin
                if (ud) begin
                    if (m_count == 9) begin m_tc = 1; if (!md) m_count = 0; end
                    else m_count = m_count + 1;
                end else begin
                    if (m_count == 0) begin m_tc = 1; if (!md) m_count = 9; end
                    else m_count = m_count - 1;
                end
            end
        end
        sb_q.push_back({m_count[3:0], m_tc, m_tick, (m_count == 9), (m_count == 0)});
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [8:0] rows[5] = '{9'b0_0_0_1_0_0000, 9'b1_0_1_1_0_0110, 9'b0_0_0_1_0_0000,
                                9'b1_0_1_1_0_0110, 9'b0_1_1_1_0_0011};
        logic [8:0] r;
        logic [7:0] exp, got;
        for (int i = 0; i < 5; i++) begin
            r = rows[i];
            apply(r[8], r[7], r[6], r[5], r[4], int'(r[3:0]));
            exp = sb_q.pop_front();
            got = {count_a, tc_a, tick_a, at_max_a, at_min_a};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_sb[%0d]: got %b required %b", i, got, exp);
            end
            if (i == 1 || i == 3) begin
                n_cmp++;
                if (count_a !== 4'd6) begin
                    n_fail++;
                    $display("FAIL reset_preload[%0d]: count %0d required 6", i, count_a);
                end
            end
            if (i == 2 || i == 4) begin
                n_cmp++;
                if (got !== 8'b0000_0001) begin
                    n_fail++;
                    $display("FAIL reset_state[%0d]: got %b required 00000001", i, got);
                end
            end
        end
    endtask

    task automatic test_up_wrap();
        logic [7:0] exp, got;
        int ticks = 0, tcs = 0, amax = 0;
        apply(0, 0, 0, 1, 0, 0);
        void'(sb_q.pop_front());
        for (int i = 1; i <= 30; i++) begin
            apply(1, 1, 0, 1, 0, 0);
            exp = sb_q.pop_front();
            got = {count_a, tc_a, tick_a, at_max_a, at_min_a};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL up_wrap[%0d]: got %b required %b", i, got, exp);
            end
            if (tick_a) ticks++;
            if (tc_a) tcs++;
            if (at_max_a) amax++;
        end
        n_cmp++;
        if (ticks != 10 || tcs != 1 || amax != 3) begin
            n_fail++;
            $display("FAIL up_wrap_counts: ticks %0d tc %0d at_max %0d required 10 1 3",
                     ticks, tcs, amax);
        end
        n_cmp++;
        if (count_a !== 4'd0 || tc_a !== 1'b1) begin
            n_fail++;
            $display("FAIL up_wrap_end: count %0d tc %b required 0 1", count_a, tc_a);
        end
    endtask

    task automatic test_down_sat();
        logic [7:0] exp, got;
        int exp_c[4] = '{1, 0, 0, 0};
        bit exp_t[4] = '{0, 0, 1, 1};
        int seen_c[4];
        bit seen_t[4];
        bit seen_m[4];
        int k = 0;
        apply(1, 0, 1, 1, 0, 2);
        exp = sb_q.pop_front();
        got = {count_a, tc_a, tick_a, at_max_a, at_min_a};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL down_sat_load: got %b required %b", got, exp);
        end
        for (int i = 1; i <= 12; i++) begin
            apply(1, 1, 0, 0, 1, 0);
            exp = sb_q.pop_front();
            got = {count_a, tc_a, tick_a, at_max_a, at_min_a};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL down_sat[%0d]: got %b required %b", i, got, exp);
            end
            if (tick_a && k < 4) begin
                seen_c[k] = int'(count_a); seen_t[k] = tc_a; seen_m[k] = at_min_a; k++;
            end
        end
        n_cmp++;
        if (k != 4) begin
            n_fail++;
            $display("FAIL down_sat_steps: saw %0d steps required 4", k);
        end
        for (int j = 0; j < k; j++) begin
            n_cmp++;
            if (seen_c[j] != exp_c[j] || seen_t[j] != exp_t[j] || seen_m[j] != (exp_c[j] == 0)) begin
                n_fail++;
                $display("FAIL down_sat_step[%0d]: count %0d tc %b at_min %b required %0d %b %b",
                         j, seen_c[j], seen_t[j], seen_m[j], exp_c[j], exp_t[j], exp_c[j] == 0);
            end
        end
    endtask

    task automatic test_load_clamp();
        logic [7:0] exp, got;
        int first = 0;
        apply(1, 1, 1, 1, 1, 13);
        exp = sb_q.pop_front();
        got = {count_a, tc_a, tick_a, at_max_a, at_min_a};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL clamp_sb: got %b required %b", got, exp);
        end
        n_cmp++;
        if (count_a !== 4'd9 || tick_a !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp_value: count %0d tick %b required 9 0", count_a, tick_a);
        end
        for (int i = 1; i <= 6; i++) begin
            apply(1, 1, 0, 1, 1, 0);
            exp = sb_q.pop_front();
            got = {count_a, tc_a, tick_a, at_max_a, at_min_a};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL clamp_sat[%0d]: got %b required %b", i, got, exp);
            end
            if (tick_a && first == 0) first = i;
        end
        n_cmp++;
        if (first != 3) begin
            n_fail++;
            $display("FAIL clamp_first_step: cycle %0d required 3", first);
        end
        apply(1, 0, 1, 1, 0, 5);
        void'(sb_q.pop_front());
        n_cmp++;
        if (count_a !== 4'd5) begin
            n_fail++;
            $display("FAIL load5: count %0d required 5", count_a);
        end
    endtask

    task automatic test_enable_gating();
        logic [7:0] exp, got;
        int first = 0;
        apply(1, 1, 0, 1, 0, 0);
        void'(sb_q.pop_front());
        for (int i = 1; i <= 10; i++) begin
            apply(1, 0, 0, 0, 1, 0);
            exp = sb_q.pop_front();
            got = {count_a, tc_a, tick_a, at_max_a, at_min_a};
            n_cmp++;
            if (got !== exp || count_a !== 4'd5 || tick_a !== 1'b0) begin
                n_fail++;
                $display("FAIL gate_hold[%0d]: got %b required %b (count 5, no tick)", i, got, exp);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            apply(1, 1, 0, 1, 0, 0);
            exp = sb_q.pop_front();
            got = {count_a, tc_a, tick_a, at_max_a, at_min_a};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL gate_resume[%0d]: got %b required %b", i, got, exp);
            end
            if (tick_a && first == 0) begin
                first = i;
                n_cmp++;
                if (count_a !== 4'd6) begin
                    n_fail++;
                    $display("FAIL gate_step_value: count %0d required 6", count_a);
                end
            end
        end
        n_cmp++;
        if (first != 2) begin
            n_fail++;
            $display("FAIL gate_first_step: cycle %0d required 2", first);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp, got;
        int first = 0;
        apply(1, 0, 1, 1, 0, 7);
        void'(sb_q.pop_front());
        apply(1, 1, 0, 1, 0, 0);
        void'(sb_q.pop_front());
        apply(1, 1, 0, 1, 0, 0);
        void'(sb_q.pop_front());
        n_cmp++;
        if (count_a !== 4'd7 || tick_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pre: count %0d tick %b required 7 0", count_a, tick_a);
        end
        apply(0, 1, 0, 1, 0, 0);
        void'(sb_q.pop_front());
        got = {count_a, tc_a, tick_a, at_max_a, at_min_a};
        n_cmp++;
        if (got !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL mid_reset: got %b required 00000001", got);
        end
        for (int i = 1; i <= 5; i++) begin
            apply(1, 1, 0, 1, 0, 0);
            exp = sb_q.pop_front();
            got = {count_a, tc_a, tick_a, at_max_a, at_min_a};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL mid_after[%0d]: got %b required %b", i, got, exp);
            end
            if (tick_a && first == 0) first = i;
        end
        n_cmp++;
        if (first != 3) begin
            n_fail++;
            $display("FAIL mid_first_step: cycle %0d required 3", first);
        end
    endtask

    task automatic test_width8();
        logic [11:0] exp, got;
        int v;
        rst_n_b = 0; en_b = 1; ld_b = 0; ud_b = 1; md_b = 0; d_b = '0;
        sb_b.push_back({8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(posedge clk); #1;
        for (int i = 0; i <= 260; i++) begin
            if (i > 0) begin
                rst_n_b = 1; en_b = 1; ld_b = 0; ud_b = 1; md_b = 0;
                v = i % 256;
                sb_b.push_back({v[7:0], (i == 256), 1'b1, (v == 255), (v == 0)});
                @(posedge clk); #1;
            end
            exp = sb_b.pop_front();
            got = {count_b, tc_b, tick_b, at_max_b, at_min_b};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL w8_wrap[%0d]: got %h required %h", i, got, exp);
            end
        end
        for (int i = 0; i < 3; i++) begin
            ld_b = (i == 0); d_b = 8'd255; md_b = 1; ud_b = 1; en_b = 1;
            sb_b.push_back({8'd255, (i != 0), (i != 0), 1'b1, 1'b0});
            @(posedge clk); #1;
            exp = sb_b.pop_front();
            got = {count_b, tc_b, tick_b, at_max_b, at_min_b};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL w8_sat[%0d]: got %h required %h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_load_clamp();
        test_enable_gating();
        test_mid_reset();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
